// File: rtl/carry_skip_mw_seq.sv
// -----------------------------------------------------------------------------
// carry_skip_mw_seq
//
// Multi-cycle wide adder. One shared 16-bit carry-skip adder processes the
// operands one 16-bit slice per clock, least significant slice first. The
// carry between slices is held in a register. Compared with a full-width
// adder, this design takes more cycles but uses less logic.
//
// Optional feature (compile-time macro SUBTRACT_EN):
//   When SUBTRACT_EN is defined, the op_sub port is added. With op_sub=1 the
//   block computes A-B mod 2^W, and out_cout=1 means "no borrow".
//   When SUBTRACT_EN is undefined, the block only adds.
//
// Parameters:
//   WORDS      number of 16-bit slices (2..16); operand width W = 16*WORDS
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request
//   in_ready   block can accept operands (registered; low during reset)
//   in_a/in_b  W-bit operands
//   in_cin     carry into slice 0
//   op_sub     (SUBTRACT_EN only) subtract instead of add
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_sum    registered W-bit sum
//   out_cout   carry out of the top slice
//   busy       high while an operation is in flight or waiting for handoff
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds valid and data until that edge. The consumer
// may drive ready independently of valid. in_ready is low outside IDLE, so an
// accept never falls in the same cycle as a result handoff.
// -----------------------------------------------------------------------------

// 16-bit carry-skip adder: four 4-bit ripple blocks. A block whose bits all
// propagate passes its carry-in straight to its carry-out.
module carry_skip_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [4:0] blk_c;

    always_comb begin
        logic       c;
        logic [3:0] p;
        blk_c    = '0;
        sum      = '0;
        cout     = 1'b0;
        c        = 1'b0;
        p        = '0;
        blk_c[0] = cin;
        for (int k = 0; k < 4; k++) begin
            c = blk_c[k];
            for (int j = 0; j < 4; j++) begin
                p[j]         = a[4*k+j] ^ b[4*k+j];
                sum[4*k+j]   = p[j] ^ c;
                c            = (a[4*k+j] & b[4*k+j]) | (p[j] & c);
            end
            // Skip path: when the whole block propagates, its carry-out
            // equals its carry-in.
            blk_c[k+1] = (&p) ? blk_c[k] : c;
        end
        cout = blk_c[4];
    end
endmodule

module carry_skip_mw_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] in_a,
    input  logic [16*WORDS-1:0] in_b,
    input  logic                in_cin,
`ifdef SUBTRACT_EN
    input  logic                op_sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] out_sum,
    output logic                out_cout,
    output logic                busy
);
    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          cout_q;
    logic          rdy_q;
    logic [IW-1:0] idx;
`ifdef SUBTRACT_EN
    logic          sub_q;
`endif

    // Bit offset of the current slice. idx*16 needs exactly IW+4 bits,
    // which is also the index width of a W-bit vector.
    logic [IW+3:0] base;
    logic [15:0]   a16;
    logic [15:0]   b16;
    logic [15:0]   s16;
    logic          c16;
    logic          accept;
    logic          last;

    assign base   = {idx, 4'b0000};
    assign accept = in_valid & rdy_q;
    assign last   = (idx == IW'(WORDS - 1));
    assign a16    = op_a[base +: 16];
`ifdef SUBTRACT_EN
    assign b16    = sub_q ? ~op_b[base +: 16] : op_b[base +: 16];
`else
    assign b16    = op_b[base +: 16];
`endif

    carry_skip_16bit u_add (
        .a    (a16),
        .b    (b16),
        .cin  (carry_q),
        .sum  (s16),
        .cout (c16)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept)    state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Datapath. in_ready is registered so that it is low during reset and
    // rises on the first edge after release. When idx is 0, carry_q holds the
    // captured slice-0 carry-in, so the adder always takes its carry from
    // carry_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx     <= '0;
`ifdef SUBTRACT_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            rdy_q <= (state_nx == IDLE);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= in_a;
                        op_b    <= in_b;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        idx     <= '0;
`ifdef SUBTRACT_EN
                        sub_q   <= op_sub;
                        // For subtraction, A + ~B + 1: the carry-in is forced to 1.
                        carry_q <= op_sub | in_cin;
`else
                        carry_q <= in_cin;
`endif
                    end
                end
                RUN: begin
                    sum_q[base +: 16] <= s16;
                    carry_q           <= c16;
                    if (last) begin
                        cout_q <= c16;
                        idx    <= '0;
                    end else begin
                        idx    <= idx + IW'(1);
                    end
                end
                default: begin
                    // DONE: the result is held until handoff.
                end
            endcase
        end
    end

`ifdef SUBTRACT_EN
    // The forced carry-in must ignore in_cin when op_sub=1. The expression
    // above ORs them, which works only when op_sub wins; make that explicit.
`endif

    assign in_ready  = rdy_q;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_carry_skip_mw_seq.sv
// -----------------------------------------------------------------------------
// tb_carry_skip_mw_seq
//
// Self-checking bench for carry_skip_mw_seq (WORDS=4). It runs directed
// scenarios followed by randomized operations. The expected result of each
// operation is computed with plain (W+1)-bit arithmetic and queued in a
// scoreboard. The queued value is compared when out_valid is observed.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_carry_skip_mw_seq;
    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_cin    = 1'b0;
    logic         out_ready = 1'b0;
    logic         op_sub    = 1'b0;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_cout;
    logic         busy;
    logic [W-1:0] out_sum;

    logic [W:0]   exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    carry_skip_mw_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef SUBTRACT_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // {cout, sum} of A+B+cin, or of A-B as A+~B+1.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        logic [W:0] r;
        if (sub) r = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else     r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        return r;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < WORDS; i++) r = {r[W-17:0], 16'($urandom)};
        return r;
    endfunction

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Presents operands, waits for in_ready, and returns 1 unit after the
    // accept edge with the expected result queued.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub);
        int n;
        in_a  = a;
        in_b  = b;
        in_cin = cin;
`ifdef SUBTRACT_EN
        op_sub = sub;
`else
        op_sub = 1'b0;
        if (sub) $display("note: subtract request ignored in add-only build");
`endif
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("in_ready_wait", (W+1)'(in_ready), (W+1)'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(model(a, b, cin, op_sub));
        check_val("busy_after_accept", (W+1)'(busy), (W+1)'(1));
        check_val("in_ready_in_run", (W+1)'(in_ready), (W+1)'(0));
    endtask

    // Waits for the result and checks it and its latency. Holds the result for
    // 'hold' cycles of backpressure, then hands it off. If keep_valid is 0, the
    // operand inputs are driven with noise while the block is busy.
    task automatic finish_op(input int hold, input logic keep_valid, output logic [W:0] got);
        int         lat;
        logic [W:0] exp;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        check_val("latency", (W+1)'(lat), (W+1)'(WORDS));
        got = {out_cout, out_sum};
        check_val("sb_depth", (W+1)'(exp_q.size()), (W+1)'(1));
        if (exp_q.size() != 0) exp = exp_q.pop_front();
        else                   exp = '0;
        check_val("result", got, exp);
        for (int i = 0; i < hold; i++) begin
            if (!keep_valid) begin
                in_valid = 1'($urandom_range(0, 1));
                in_a     = rand_w();
                in_b     = rand_w();
                in_cin   = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            check_val("hold_result", {out_cout, out_sum}, got);
            check_val("hold_valid", (W+1)'(out_valid), (W+1)'(1));
            check_val("hold_in_ready", (W+1)'(in_ready), (W+1)'(0));
        end
        if (!keep_valid) in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("valid_after_handoff", (W+1)'(out_valid), (W+1)'(0));
        check_val("busy_after_handoff", (W+1)'(busy), (W+1)'(0));
        check_val("ready_after_handoff", (W+1)'(in_ready), (W+1)'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_in_ready"}, (W+1)'(in_ready), (W+1)'(0));
        check_val({tag, "_out_valid"}, (W+1)'(out_valid), (W+1)'(0));
        check_val({tag, "_out_sum"}, (W+1)'(out_sum), (W+1)'(0));
        check_val({tag, "_out_cout"}, (W+1)'(out_cout), (W+1)'(0));
        check_val({tag, "_busy"}, (W+1)'(busy), (W+1)'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [W:0]   got;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Reset state and in_ready rising on the first edge after release.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        check_val("ready_before_edge", (W+1)'(in_ready), (W+1)'(0));
        @(posedge clk); #1;
        check_val("ready_after_release", (W+1)'(in_ready), (W+1)'(1));

        // Small sum with carry-in.
        start_op(64'h5, 64'h5, 1'b1, 1'b0);
        finish_op(0, 1'b0, got);
        check_val("tp1_const", got, 65'h0_0000_0000_0000_000B);

        // Carry through all four slices.
        start_op({W{1'b1}}, '0, 1'b1, 1'b0);
        finish_op(1, 1'b0, got);
        check_val("tp2_const", got, 65'h1_0000_0000_0000_0000);

        // Carry from slice 0 to slice 1 through the carry register.
        start_op(64'hFFFF, 64'h1, 1'b0, 1'b0);
        finish_op(0, 1'b0, got);
        check_val("tp3_const", got, 65'h0_0000_0000_0001_0000);

        // Backpressure: new operands are presented the whole time.
        start_op(64'h5, 64'h5, 1'b1, 1'b0);
        a2 = 64'h0123_4567_89AB_CDEF;
        b2 = 64'h1111_2222_FFFF_3333;
        in_a     = a2;
        in_b     = b2;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        finish_op(5, 1'b1, got);
        check_val("tp4_const", got, 65'h0_0000_0000_0000_000B);
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(model(a2, b2, 1'b0, op_sub));
        check_val("tp4_accept_after_idle", (W+1)'(busy), (W+1)'(1));
        finish_op(0, 1'b0, got);

        // Reset in the second RUN cycle aborts the operation.
        start_op(64'h0000_0000_0000_1234, 64'h1, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("ready_after_midrun", (W+1)'(in_ready), (W+1)'(1));
        start_op(64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b0);
        finish_op(0, 1'b0, got);

`ifdef SUBTRACT_EN
        start_op(64'h10, 64'h20, 1'b0, 1'b1);
        finish_op(0, 1'b0, got);
        check_val("tp6a_const", got, 65'h0_FFFF_FFFF_FFFF_FFF0);
        start_op(64'h20, 64'h10, 1'b1, 1'b1);
        finish_op(0, 1'b0, got);
        check_val("tp6b_const", got, 65'h1_0000_0000_0000_0010);
`endif

        // Randomized operations, biased toward long carry chains.
        for (int i = 0; i < 24; i++) begin
            ra = rand_w();
            case ($urandom_range(0, 3))
                0:       rb = ~ra;
                1:       begin ra = {W{1'b1}}; rb = rand_w() & W'(64'hF); end
                default: rb = rand_w();
            endcase
            start_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            finish_op($urandom_range(0, 3), 1'b0, got);
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            out_ready = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
